// File: rtl/pixel_scheduler_pkg.sv
// Shared types for the pixel scheduler: FSM state encoding and the RGB888 color word.
package pixel_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef logic [23:0] color_t;

endpackage

// File: rtl/pixel_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr; after a grant the
// pointer moves to the slot just past the winner so every requester gets a turn.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            for (int j = 0; j < N; j++) begin
                if (req[j] && (j == (int'(ptr) + k) % N)) begin
                    grant    = '0;
                    grant[j] = 1'b1;
                    next_ptr = PW'((j + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr <= '0;
        end else if (|req) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/pixel_scheduler.sv
// Dispatches frame pixels in raster order to a pool of raymarcher cores and funnels
// their results, one per cycle, into the frame-buffer write port.
module pixel_scheduler
    import pixel_scheduler_pkg::*;
#(
    parameter  int WIDTH     = 1280,
    parameter  int HEIGHT    = 720,
    parameter  int NUM_CORES = 3,
    localparam int XW        = $clog2(WIDTH),
    localparam int YW        = $clog2(HEIGHT),
    localparam int AW        = $clog2(WIDTH * HEIGHT)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable_in,
    output logic [NUM_CORES-1:0]    core_start_out,
    output logic [XW-1:0]           core_x_out,
    output logic [YW-1:0]           core_y_out,
    input  logic [NUM_CORES-1:0]    core_done_in,
    input  logic [24*NUM_CORES-1:0] core_color_in,
    input  logic [XW*NUM_CORES-1:0] core_ox_in,
    input  logic [YW*NUM_CORES-1:0] core_oy_in,
    output logic                    fb_we_out,
    output logic [AW-1:0]           fb_addr_out,
    output logic [23:0]             fb_data_out,
    output logic                    frame_start_out,
    output logic                    frame_done_out,
    output logic [31:0]             timer_out,
    output logic [NUM_CORES-1:0]    busy_out,
    output state_t                  state_out
);

    localparam int TOTAL = WIDTH * HEIGHT;

    state_t               state;
    logic [XW-1:0]        ras_x;
    logic [YW-1:0]        ras_y;
    logic [NUM_CORES-1:0] busy;
    logic [NUM_CORES-1:0] slot_valid;
    color_t               slot_color [NUM_CORES];
    logic [XW-1:0]        slot_ox    [NUM_CORES];
    logic [YW-1:0]        slot_oy    [NUM_CORES];
    logic [NUM_CORES-1:0] grant;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] pick;
    logic [AW-1:0]        wr_cnt;
    color_t               gnt_color;
    logic [XW-1:0]        gnt_ox;
    logic [YW-1:0]        gnt_oy;
    logic [AW-1:0]        gnt_addr;
    logic                 committed;

    assign state_out = state;
    assign busy_out  = busy;

    // A core pulsed this cycle is not yet busy, so it is excluded explicitly.
    assign eligible  = ~busy & ~slot_valid & ~core_start_out;
    assign pick      = eligible & (~eligible + NUM_CORES'(1));
    assign committed = (busy == '0) && (slot_valid == '0) && (core_start_out == '0)
                       && !fb_we_out && (wr_cnt == '0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= IDLE;
            ras_x           <= '0;
            ras_y           <= '0;
            core_start_out  <= '0;
            core_x_out      <= '0;
            core_y_out      <= '0;
            frame_start_out <= 1'b0;
        end else begin
            core_start_out  <= '0;
            frame_start_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_in) begin
                        state           <= FRAME;
                        frame_start_out <= 1'b1;
                    end
                end
                FRAME: state <= RUN;
                RUN: begin
                    if (|pick) begin
                        core_start_out <= pick;
                        core_x_out     <= ras_x;
                        core_y_out     <= ras_y;
                        if (ras_x == XW'(WIDTH - 1)) begin
                            ras_x <= '0;
                            if (ras_y == YW'(HEIGHT - 1)) begin
                                ras_y <= '0;
                                state <= DRAIN;
                            end else begin
                                ras_y <= ras_y + YW'(1);
                            end
                        end else begin
                            ras_x <= ras_x + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (committed) begin
                        if (enable_in) begin
                            state           <= FRAME;
                            frame_start_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A core only restarts once its slot drains, so capture never overwrites a valid slot.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy       <= '0;
            slot_valid <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_color[i] <= '0;
                slot_ox[i]    <= '0;
                slot_oy[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_start_out[i]) begin
                    busy[i] <= 1'b1;
                end else if (busy[i] && core_done_in[i]) begin
                    busy[i] <= 1'b0;
                end
                if (busy[i] && core_done_in[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_color[i] <= core_color_in[24*i +: 24];
                    slot_ox[i]    <= core_ox_in[XW*i +: XW];
                    slot_oy[i]    <= core_oy_in[YW*i +: YW];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .req    (slot_valid),
        .grant  (grant)
    );

    always_comb begin
        gnt_color = '0;
        gnt_ox    = '0;
        gnt_oy    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                gnt_color = slot_color[i];
                gnt_ox    = slot_ox[i];
                gnt_oy    = slot_oy[i];
            end
        end
    end

    assign gnt_addr = AW'(32'(gnt_ox) + 32'(WIDTH) * 32'(gnt_oy));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fb_we_out      <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= '0;
            wr_cnt         <= '0;
            frame_done_out <= 1'b0;
            timer_out      <= '0;
        end else begin
            fb_we_out      <= |grant;
            fb_addr_out    <= gnt_addr;
            fb_data_out    <= gnt_color;
            frame_done_out <= 1'b0;
            if (fb_we_out) begin
                if (wr_cnt == AW'(TOTAL - 1)) begin
                    wr_cnt         <= '0;
                    frame_done_out <= 1'b1;
                    timer_out      <= timer_out + 32'd1;
                end else begin
                    wr_cnt <= wr_cnt + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler on a 4x2 frame with three modelled cores of programmable latency.
module tb_pixel_scheduler;
    import pixel_scheduler_pkg::*;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int N     = 3;
    localparam int XW    = 2;
    localparam int YW    = 1;
    localparam int AW    = 3;
    localparam int TOTAL = W * H;

    typedef struct {
        int lat0;
        int lat1;
        int lat2;
        int frames;
        bit spur;
        bit chk_order;
        int exp_timer;
        int exp_writes;
    } vec_t;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            enable_in = 1'b0;
    logic [N-1:0]    core_start_out;
    logic [XW-1:0]   core_x_out;
    logic [YW-1:0]   core_y_out;
    logic [N-1:0]    core_done_in = '0;
    logic [24*N-1:0] core_color_in = '0;
    logic [XW*N-1:0] core_ox_in = '0;
    logic [YW*N-1:0] core_oy_in = '0;
    logic            fb_we_out;
    logic [AW-1:0]   fb_addr_out;
    logic [23:0]     fb_data_out;
    logic            frame_start_out;
    logic            frame_done_out;
    logic [31:0]     timer_out;
    logic [N-1:0]    busy_out;
    state_t          state_out;

    int total = 0;
    int bad   = 0;

    // Core and scoreboard model state, owned by the negedge monitor.
    int          lat [N];
    bit          spur_en = 1'b0;
    bit          computing [N];
    bit          outstanding [N];
    int          cnt [N];
    int          px [N];
    int          py [N];
    bit          written [TOTAL];
    bit          frame_open;
    bit          fd_due;
    int          starts_in_frame;
    int          frame_writes;
    logic [31:0] m_timer;
    int          fs_count = 0;
    int          wr_total = 0;
    int          cyc = 0;
    int          owner;
    int          a;
    logic [N-1:0] exp_busy;
    int          wr_log[$];
    int          wrcyc_log[$];

    pixel_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(N)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .core_start_out  (core_start_out),
        .core_x_out      (core_x_out),
        .core_y_out      (core_y_out),
        .core_done_in    (core_done_in),
        .core_color_in   (core_color_in),
        .core_ox_in      (core_ox_in),
        .core_oy_in      (core_oy_in),
        .fb_we_out       (fb_we_out),
        .fb_addr_out     (fb_addr_out),
        .fb_data_out     (fb_data_out),
        .frame_start_out (frame_start_out),
        .frame_done_out  (frame_done_out),
        .timer_out       (timer_out),
        .busy_out        (busy_out),
        .state_out       (state_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [23:0] color_of(input int x, input int y);
        return 24'(x * 40961 + y * 1297 + 73);
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model plus scoreboard: every pixel written exactly once per frame with the
    // color its coordinates imply, starts in raster order, done pulse after the 8th write.
    always @(negedge clk_in) begin
        cyc++;
        if (rst_in) begin
            for (int i = 0; i < N; i++) begin
                computing[i]   = 1'b0;
                outstanding[i] = 1'b0;
                cnt[i]         = 0;
            end
            for (int k = 0; k < TOTAL; k++) written[k] = 1'b0;
            core_done_in    = '0;
            core_color_in   = '0;
            core_ox_in      = '0;
            core_oy_in      = '0;
            frame_open      = 1'b0;
            fd_due          = 1'b0;
            starts_in_frame = 0;
            frame_writes    = 0;
            m_timer         = '0;
            wr_log.delete();
            wrcyc_log.delete();
        end else begin
            for (int i = 0; i < N; i++) exp_busy[i] = computing[i];
            check(busy_out == exp_busy, "busy_out", longint'(busy_out), longint'(exp_busy));

            if (frame_done_out || fd_due) begin
                check(frame_done_out == fd_due, "frame_done_timing", longint'(frame_done_out), longint'(fd_due));
                if (fd_due) begin
                    m_timer = m_timer + 32'd1;
                    check(timer_out == m_timer, "timer_at_done", longint'(timer_out), longint'(m_timer));
                end
            end
            fd_due = 1'b0;

            if (fb_we_out) begin
                a = int'(fb_addr_out);
                wr_total++;
                wr_log.push_back(a);
                wrcyc_log.push_back(cyc);
                check(!written[a], "fb_addr_once", a, -1);
                check(fb_data_out == color_of(a % W, a / W), "fb_data", longint'(fb_data_out),
                      longint'(color_of(a % W, a / W)));
                owner = -1;
                for (int i = 0; i < N; i++)
                    if (outstanding[i] && (px[i] + W * py[i] == a)) owner = i;
                check(owner >= 0, "write_owner", a, -1);
                if (owner >= 0) outstanding[owner] = 1'b0;
                written[a] = 1'b1;
                frame_writes++;
                if (frame_writes == TOTAL) begin
                    fd_due       = 1'b1;
                    frame_writes = 0;
                    frame_open   = 1'b0;
                    for (int k = 0; k < TOTAL; k++) written[k] = 1'b0;
                end
            end

            if (frame_start_out) begin
                fs_count++;
                check(!frame_open, "frame_start_gate", longint'(frame_open), 0);
                frame_open      = 1'b1;
                starts_in_frame = 0;
            end

            core_done_in = '0;
            for (int i = 0; i < N; i++) begin
                if (computing[i]) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        computing[i]               = 1'b0;
                        core_done_in[i]            = 1'b1;
                        core_color_in[24*i +: 24]  = color_of(px[i], py[i]);
                        core_ox_in[XW*i +: XW]     = XW'(px[i]);
                        core_oy_in[YW*i +: YW]     = YW'(py[i]);
                    end
                end else if (spur_en && $urandom_range(0, 5) == 0) begin
                    core_done_in[i]           = 1'b1;
                    core_color_in[24*i +: 24] = 24'($urandom);
                    core_ox_in[XW*i +: XW]    = XW'($urandom);
                    core_oy_in[YW*i +: YW]    = YW'($urandom);
                end
            end

            if (core_start_out != '0) begin
                check($countones(core_start_out) == 1, "start_onehot", longint'(core_start_out), 1);
                for (int i = 0; i < N; i++) begin
                    if (core_start_out[i]) begin
                        check(!outstanding[i], "start_core_free", i, -1);
                        check(frame_open && starts_in_frame < TOTAL, "start_in_frame", starts_in_frame, TOTAL);
                        check(int'(core_x_out) == starts_in_frame % W && int'(core_y_out) == starts_in_frame / W,
                              "start_xy", int'(core_y_out) * W + int'(core_x_out), starts_in_frame);
                        px[i]           = int'(core_x_out);
                        py[i]           = int'(core_y_out);
                        computing[i]    = 1'b1;
                        outstanding[i]  = 1'b1;
                        cnt[i]          = lat[i];
                        core_done_in[i] = 1'b0;
                        starts_in_frame++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({core_start_out, fb_we_out, frame_start_out, frame_done_out, busy_out, state_out} == '0,
              {tag, "_ctrl_zero"},
              longint'({core_start_out, fb_we_out, frame_start_out, frame_done_out, busy_out, state_out}), 0);
        check({core_x_out, core_y_out, fb_addr_out, fb_data_out} == '0, {tag, "_data_zero"},
              longint'({core_x_out, core_y_out, fb_addr_out, fb_data_out}), 0);
        check(timer_out == 32'd0, {tag, "_timer_zero"}, longint'(timer_out), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        rst_in    = 1'b1;
        enable_in = 1'b0;
        repeat (2) step();
        rst_in = 1'b0;
        step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int fs0;
        int wr0;
        apply_reset();
        lat[0]  = v.lat0;
        lat[1]  = v.lat1;
        lat[2]  = v.lat2;
        spur_en = v.spur;
        fs0 = fs_count;
        wr0 = wr_total;
        enable_in = 1'b1;
        for (int k = 0; k < 5000 && (fs_count - fs0) < v.frames; k++) step();
        enable_in = 1'b0;
        check(fs_count - fs0 == v.frames, "frames_started_in_time", fs_count - fs0, v.frames);
        for (int k = 0; k < 5000 && state_out != IDLE; k++) step();
        repeat (20) step();
        spur_en = 1'b0;
        check(state_out == IDLE, "idle_after_drop", longint'(state_out), longint'(IDLE));
        check(fs_count - fs0 == v.frames, "no_extra_frame_start", fs_count - fs0, v.frames);
        check(timer_out == 32'(v.exp_timer), "timer_final", longint'(timer_out), v.exp_timer);
        check(wr_total - wr0 == v.exp_writes, "write_total", wr_total - wr0, v.exp_writes);
        if (v.chk_order) begin
            check(wr_log.size() >= 6, "order_log_len", wr_log.size(), 6);
            if (wr_log.size() >= 6) begin
                for (int k = 0; k < 6; k++)
                    check(wr_log[k] == k, "grant_order_addr", wr_log[k], k);
                for (int k = 1; k < 6; k++)
                    if (k != 3)
                        check(wrcyc_log[k] == wrcyc_log[k-1] + 1, "grant_back_to_back",
                              wrcyc_log[k] - wrcyc_log[k-1], 1);
            end
        end
        if (idx < 0) $display("unreachable %0d", idx);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{lat0: 5,  lat1: 5, lat2: 5, frames: 1, spur: 0, chk_order: 0, exp_timer: 1, exp_writes: 8};
        vecs[1] = '{lat0: 7,  lat1: 6, lat2: 5, frames: 2, spur: 0, chk_order: 1, exp_timer: 2, exp_writes: 16};
        vecs[2] = '{lat0: 20, lat1: 2, lat2: 2, frames: 2, spur: 0, chk_order: 0, exp_timer: 2, exp_writes: 16};
        vecs[3] = '{lat0: 2,  lat1: 20, lat2: 2, frames: 3, spur: 1, chk_order: 0, exp_timer: 3, exp_writes: 24};
        vecs[4] = '{lat0: 1,  lat1: 1, lat2: 1, frames: 3, spur: 1, chk_order: 0, exp_timer: 3, exp_writes: 24};
        for (int r = 5; r < 8; r++) begin
            vecs[r].lat0      = $urandom_range(1, 12);
            vecs[r].lat1      = $urandom_range(1, 12);
            vecs[r].lat2      = $urandom_range(1, 12);
            vecs[r].frames    = $urandom_range(1, 3);
            vecs[r].spur      = 1'b1;
            vecs[r].chk_order = 1'b0;
            vecs[r].exp_timer = vecs[r].frames;
            vecs[r].exp_writes = vecs[r].frames * TOTAL;
        end
        lat[0] = 5;
        lat[1] = 5;
        lat[2] = 5;

        repeat (3) step();
        check_outputs_zero("reset");
        rst_in = 1'b0;
        step();

        for (int r = 0; r < 8; r++) run_vec(vecs[r], r);

        // Reset mid-RUN with two cores in flight, starting from a nonzero timer.
        check(timer_out != 32'd0, "timer_nonzero_before_reset", longint'(timer_out), 1);
        lat[0] = 10;
        lat[1] = 10;
        lat[2] = 10;
        enable_in = 1'b1;
        for (int k = 0; k < 200 && $countones(busy_out) < 2; k++) step();
        check($countones(busy_out) >= 2, "two_busy_before_reset", $countones(busy_out), 2);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check_outputs_zero("midrun_reset");
        repeat (2) step();
        rst_in = 1'b0;
        for (int k = 0; k < 50 && core_start_out == '0; k++) step();
        check(core_start_out != '0, "start_after_reset", longint'(core_start_out), 1);
        check(core_x_out == '0 && core_y_out == '0, "first_start_origin",
              longint'({core_y_out, core_x_out}), 0);
        check(timer_out == 32'd0, "timer_after_reset", longint'(timer_out), 0);
        enable_in = 1'b0;
        for (int k = 0; k < 2000 && state_out != IDLE; k++) step();
        repeat (5) step();
        check(timer_out == 32'd1, "timer_after_reset_frame", longint'(timer_out), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 1280: frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 720: frame height in pixels.
REQ-003 SHALL have parameter NUM_CORES, default 3: number of raymarcher cores scheduled; XW=$clog2(WIDTH), YW=$clog2(HEIGHT), AW=$clog2(WIDTH*HEIGHT).
REQ-004 SHALL have one clock and asynchronous active-high reset: clk_in  input  1  sole clock; rst_in  input  1  reset.
REQ-005 enable_in  input  1  permits starting a new frame.
REQ-006 core_start_out  output  NUM_CORES  one-cycle start pulse per core.
REQ-007 core_x_out  output  XW, core_y_out  output  YW: pixel coordinate for the pulsed start.
REQ-008 core_done_in  input  NUM_CORES: per-core one-cycle pixel_done.
REQ-009 core_color_in  input  24*NUM_CORES; core_ox_in  input  XW*NUM_CORES; core_oy_in  input  YW*NUM_CORES: per-core result, core i in slice i.
REQ-010 fb_we_out  output  1; fb_addr_out  output  AW; fb_data_out  output  24: frame-buffer write port.
REQ-011 frame_start_out  output  1: one-cycle pulse; parent latches camera vectors on it.
REQ-012 frame_done_out  output  1: one-cycle pulse after the last write of a frame.
REQ-013 timer_out  output  32: completed-frame count.
REQ-014 busy_out  output  NUM_CORES: core i in flight.

Function
REQ-015 FSM states: IDLE, FRAME, RUN, DRAIN.
- IDLE -> FRAME when enable_in=1.
- FRAME lasts one cycle, asserts frame_start_out, then RUN.
- RUN -> DRAIN on the cycle pixel (WIDTH-1,HEIGHT-1) is dispatched.
- DRAIN -> FRAME (enable_in=1) or IDLE (enable_in=0) once all busy bits, result slots and write counter indicate the frame is committed.
REQ-016 In RUN, at most one start per cycle, to the lowest-index core with busy=0 and result slot empty.
- core_start_out and core_x/y_out are registered together.
- Raster advances x-first: x wraps at WIDTH-1; y increments on x wrap and wraps at HEIGHT-1.
REQ-017 busy[i] SHALL set the cycle after start and clear the cycle after core_done_in[i].
- core_done_in[i] while busy[i]=0 SHALL be ignored.
REQ-018 On a valid done, slot i SHALL capture color/ox/oy and set valid the next cycle.
REQ-019 Write arbiter:
- round-robin over valid slots, one grant per cycle;
- pointer moves to granted index+1 mod NUM_CORES;
- grant clears that slot's valid;
- fb_we_out/addr/data registered, fb_addr_out = ox + WIDTH*oy, truncated to AW;
- done-to-write latency is 2 cycles minimum.
REQ-020 Simultaneous dones from all cores SHALL all be captured; none is dropped.
REQ-021 Write counter increments per fb_we_out. When it reaches WIDTH*HEIGHT it wraps to 0; frame_done_out pulses and timer_out increments in the same cycle.
REQ-022 enable_in deassertion takes effect only at the DRAIN exit; a frame in progress always completes.
REQ-023 timer_out SHALL wrap modulo 2^32.

Reset
REQ-024 On rst_in (asynchronous, independent of clk_in), all of the following SHALL clear to 0:
- state (IDLE), raster x/y, busy, slots, RR pointer, write counter and timer_out;
- all outputs.
REQ-025 Reset mid-frame SHALL discard in-flight results; after release, the next frame restarts at pixel (0,0).

Structure
REQ-026 Shared package SHALL hold the state enum and the 24-bit color typedef.
REQ-027 The round-robin arbiter SHALL be a sub-module rr_arbiter (NUM_CORES requests, one-hot grant, pointer).

Verification
REQ-028 Cover WIDTH=4, HEIGHT=2, NUM_CORES=3, fixed core latency 5, enable_in=1 -> frame_start_out once, then 8 writes covering addresses 0..7 each exactly once, then frame_done_out, timer_out=1.
REQ-029 Cover all 3 cores finishing in the same cycle -> 3 consecutive fb_we_out cycles, granted in order 0,1,2; the next simultaneous batch is granted 0,1,2 again.
REQ-030 Cover enable_in dropped mid-frame -> remaining pixels still dispatched and written, then IDLE; no further frame_start_out.
REQ-031 Cover a core with latency 20 among cores with latency 2 -> DRAIN holds frame_start_out until its write lands; no pixel of the next frame starts earlier.
REQ-032 Cover rst_in asserted mid-RUN with 2 cores busy -> outputs 0 immediately; post-reset first start carries x=0, y=0; timer_out=0.
